afe_tot_array: RTL and testbench
================================

AFE_TOT_ARRAY -- requirements
Module: afe_tot_array

Interface
REQ-001 Parameter N_CH, default 4, number of comparator channels (1..8).
REQ-002 Parameter CNT_W, default 8, TOT counter width in bits (4..16).
REQ-003 Parameter GPIO_W, default 8, GPIO register width (1..16).
REQ-004 Clocking is fixed: one clock; reset is asynchronous and active-high.
REQ-005 Port CLK, input, 1, sole system clock; all state is clocked on its rising edge.
REQ-006 Port RST, input, 1, asynchronous active-high reset.
REQ-007 Port INJ_IN, input, 1, injection window; high means the measurement window is open.
REQ-008 Port COMP, input, N_CH, asynchronous comparator outputs.
REQ-009 Port CS_B, SCLK and MOSI, input, 1 each, SPI mode 0 slave, with CS_B active-low.
REQ-010 Port MISO, output, 1, SPI serial data, MSB first.
REQ-011 Port HIT, output, N_CH, per-channel registered hit flags.
REQ-012 Port INJ_OUT, output, 1, combinational copy of INJ_IN that reset does not affect.
REQ-013 Port GPIO, output, GPIO_W, registered general-purpose outputs.

Function
REQ-014 INJ_IN, COMP, CS_B, SCLK and MOSI each pass through a 2-flop synchronizer; all edge detection uses the synchronized copies.
REQ-015 An INJ_IN rising edge clears all counters and HIT flags in the cycle after the edge is detected.
REQ-016 While the window is open, counter[i] increments by 1 each CLK cycle in which synchronized COMP[i] is high.
REQ-017 HIT[i] sets on the first synchronized COMP[i] high inside the window and holds until the next INJ_IN rising edge.
REQ-018 COMP activity outside the window changes neither the counters nor HIT.
REQ-019 An INJ_IN falling edge copies all counters into result registers and sets status.valid in the same cycle.
REQ-020 SPI frame is 24 bits: bit 23 R/W (1 = write), bits 22:16 address, bits 15:0 data.
REQ-021 MOSI is sampled on the SCLK rising edge.
REQ-022 MISO updates on the SCLK falling edge, is 0 while CS_B is high, and shifts out read data during bits 15:0.
REQ-023 Address 0x00 is GPIO, read/write; GPIO bits beyond GPIO_W read 0.
REQ-024 Address 0x01 is STATUS, read-only: bit 15 valid, bits 14:8 overflow[N_CH-1:0] zero-padded, bits 7:0 HIT zero-padded.
REQ-025 Address 0x10+i is the result for channel i, read-only and zero-extended to 16 bits; an address with i >= N_CH reads 0x0000.
REQ-026 A read of any result address clears status.valid at the CS_B rising edge.
REQ-027 A write commits at the CS_B rising edge only if exactly 24 SCLK rising edges were counted; a short or long frame is discarded with no state change.
REQ-028 Writes to read-only or unmapped addresses are ignored.
REQ-029 The design requires f_CLK >= 8 x f_SCLK.
REQ-030 When a result latch and a read-clear of valid occur in the same cycle, the latch wins and valid = 1.
REQ-031 A CS_B rising edge mid-frame resets the bit counter and shifter without committing.

Reset
REQ-032 While RST is high: MISO = 0, HIT = 0, GPIO = 0, counters = 0, results = 0, valid = 0, overflow = 0, and the SPI bit counter = 0.
REQ-033 Reset takes effect asynchronously and is released synchronously, through a 2-flop release synchronizer.
REQ-034 A reset asserted mid-frame aborts the frame; the frame is not resumed after release.

Configuration
REQ-035 Macro AFE_TOT_SATURATE_EN selects counter overflow behaviour.
REQ-036 With the macro defined, counters saturate at 2^CNT_W-1 and set overflow[i] sticky until the next window opens.
REQ-037 Without the macro, counters wrap modulo 2^CNT_W and the overflow bits read 0.

Structure
REQ-038 Package afe_pkg holds the address constants (GPIO, STATUS, RESULT_BASE), FRAME_W = 24, the R/W bit index and the status bit positions.
REQ-039 Sub-module afe_spi_slave holds the SPI synchronizers, shifter, bit counter, frame-valid check and MISO driver.
REQ-040 afe_spi_slave presents the host with address, write data, write strobe, read strobe and read data.

Verification
REQ-041 Reset: release RST -> MISO = 0, HIT = 0, GPIO = 0; a read of STATUS returns 0x0000.
REQ-042 TOT: N_CH = 4, open the window, hold COMP[2] high for 37 CLK cycles, close the window -> read 0x12 returns 0x0025, HIT = 4'b0100, STATUS = 0x8004.
REQ-043 Overflow: CNT_W = 8, COMP[0] high for 300 cycles -> with the macro, 0x10 reads 0x00FF and STATUS bit 8 = 1; without the macro, 0x10 reads 0x002C.
REQ-044 GPIO: write 0x00 with 0x00A5 -> GPIO = 8'hA5 after the CS_B rise; a 23-bit write of 0x005A leaves GPIO at 8'hA5.
REQ-045 Valid clear: read 0x10 then read STATUS -> bit 15 = 0; a window closing during the read's CS_B rise leaves bit 15 = 1.
REQ-046 Gating: COMP[1] toggles with INJ_IN low -> HIT = 0 and 0x11 reads 0x0000.

Source files
------------

// File: rtl/afe_pkg.sv
// afe_pkg: SPI frame layout and register map shared by afe_tot_array and its SPI slave
package afe_pkg;
  typedef logic [6:0] addr_t;
  localparam int FRAME_W = 24;
  localparam int DATA_W = 16;
  localparam int HDR_W = FRAME_W - DATA_W;
  localparam int RW_BIT = 23;
  localparam addr_t ADDR_GPIO = 7'h00;
  localparam addr_t ADDR_STATUS = 7'h01;
  localparam addr_t ADDR_RESULT_BASE = 7'h10;
  localparam int ST_VALID_BIT = 15;
  localparam int ST_OVF_LSB = 8;
  localparam int ST_HIT_LSB = 0;
endpackage

// File: rtl/afe_spi_slave.sv
// afe_spi_slave: oversampled SPI mode-0 slave, 24-bit R/W frames, commits only complete frames at CS_B rise
module afe_spi_slave (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_b_i,
  input  logic        sclk_i,
  input  logic        mosi_i,
  input  logic [15:0] rdata_i,
  output logic [6:0]  addr_o,
  output logic [15:0] wdata_o,
  output logic        wr_o,
  output logic        rd_o,
  output logic        miso_o
);
  import afe_pkg::*;
  logic [2:0] cs_q, sclk_q;
  logic [1:0] mosi_q;
  logic [4:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] sh_q, sh_d, tx_q, tx_d;
  logic [6:0] addr_q, addr_d;
  logic rw_q, rw_d, miso_q, miso_d;
  logic cs_s, cs_rise, sclk_rise, sclk_fall, full;
  assign cs_s = cs_q[1];
  assign cs_rise = cs_q[1] & ~cs_q[2];
  assign sclk_rise = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall = ~sclk_q[1] & sclk_q[2];
  assign full = cnt_q == 5'(FRAME_W);
  assign addr_o = addr_q;
  assign wdata_o = sh_q;
  assign wr_o = cs_rise & rw_q & full;
  assign rd_o = cs_rise & ~rw_q & full;
  assign miso_o = miso_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cs_q <= '1;
      sclk_q <= '0;
      mosi_q <= '0;
      cnt_q <= '0;
      sh_q <= '0;
      tx_q <= '0;
      addr_q <= '0;
      rw_q <= 1'b0;
      miso_q <= 1'b0;
    end else begin
      cs_q <= {cs_q[1:0], cs_b_i};
      sclk_q <= {sclk_q[1:0], sclk_i};
      mosi_q <= {mosi_q[0], mosi_i};
      cnt_q <= cnt_d;
      sh_q <= sh_d;
      tx_q <= tx_d;
      addr_q <= addr_d;
      rw_q <= rw_d;
      miso_q <= miso_d;
    end
  // counter saturates so an overlong frame can never alias back to a full one
  always_comb begin
    cnt_d = cnt_q;
    sh_d = sh_q;
    tx_d = tx_q;
    addr_d = addr_q;
    rw_d = rw_q;
    miso_d = miso_q;
    if (cs_s) begin
      cnt_d = '0;
      sh_d = '0;
      tx_d = '0;
      miso_d = 1'b0;
    end else if (sclk_rise) begin
      sh_d = {sh_q[DATA_W-2:0], mosi_q[1]};
      cnt_d = &cnt_q ? cnt_q : cnt_q + 5'd1;
      if (cnt_q == 5'(HDR_W - 1)) begin
        addr_d = {sh_q[5:0], mosi_q[1]};
        rw_d = sh_q[RW_BIT - DATA_W - 1];
      end
    end else if (sclk_fall) begin
      miso_d = 1'b0;
      if (cnt_q == 5'(HDR_W)) begin
        miso_d = rdata_i[DATA_W-1];
        tx_d = {rdata_i[DATA_W-2:0], 1'b0};
      end else if (cnt_q > 5'(HDR_W) && cnt_q < 5'(FRAME_W)) begin
        miso_d = tx_q[DATA_W-1];
        tx_d = {tx_q[DATA_W-2:0], 1'b0};
      end
    end
  end
endmodule

// File: rtl/afe_tot_array.sv
// afe_tot_array: per-channel time-over-threshold counters with SPI readout; define AFE_TOT_SATURATE_EN for saturating counters
module afe_tot_array #(
  parameter int N_CH = 4,
  parameter int CNT_W = 8,
  parameter int GPIO_W = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              INJ_IN,
  input  logic [N_CH-1:0]   COMP,
  input  logic              CS_B,
  input  logic              SCLK,
  input  logic              MOSI,
  output logic              MISO,
  output logic [N_CH-1:0]   HIT,
  output logic              INJ_OUT,
  output logic [GPIO_W-1:0] GPIO
);
  import afe_pkg::*;
  logic [1:0] rst_q;
  logic rst;
  logic [2:0] inj_q;
  logic [1:0][N_CH-1:0] comp_q;
  logic [N_CH-1:0][CNT_W-1:0] cnt_q, cnt_d, res_q, res_d;
  logic [N_CH-1:0] hit_q, hit_d, ovf_q, ovf_d, comp_s;
  logic valid_q, valid_d;
  logic [GPIO_W-1:0] gpio_q, gpio_d;
  logic inj_s, inj_rise, inj_fall, wr, rd, is_res;
  logic [6:0] addr, ch;
  logic [15:0] wdata, rdata, status;
  logic unused_wdata;
  // reset asserts immediately but releases two clocks later, clean of metastability
  always_ff @(posedge CLK or posedge RST)
    if (RST) rst_q <= 2'b11;
    else rst_q <= {rst_q[0], 1'b0};
  assign rst = rst_q[1];
  assign inj_s = inj_q[1];
  assign inj_rise = inj_q[1] & ~inj_q[2];
  assign inj_fall = ~inj_q[1] & inj_q[2];
  assign comp_s = comp_q[1];
  assign ch = addr - ADDR_RESULT_BASE;
  assign is_res = addr >= ADDR_RESULT_BASE && ch < 7'(N_CH);
  assign INJ_OUT = INJ_IN;
  assign HIT = hit_q;
  assign GPIO = gpio_q;
  assign unused_wdata = ^wdata;
  afe_spi_slave u_spi (
    .clk(CLK),
    .rst(rst),
    .cs_b_i(CS_B),
    .sclk_i(SCLK),
    .mosi_i(MOSI),
    .rdata_i(rdata),
    .addr_o(addr),
    .wdata_o(wdata),
    .wr_o(wr),
    .rd_o(rd),
    .miso_o(MISO)
  );
  always_ff @(posedge CLK or posedge rst)
    if (rst) begin
      inj_q <= '0;
      comp_q <= '0;
      cnt_q <= '0;
      res_q <= '0;
      hit_q <= '0;
      ovf_q <= '0;
      valid_q <= 1'b0;
      gpio_q <= '0;
    end else begin
      inj_q <= {inj_q[1:0], INJ_IN};
      comp_q <= {comp_q[0], COMP};
      cnt_q <= cnt_d;
      res_q <= res_d;
      hit_q <= hit_d;
      ovf_q <= ovf_d;
      valid_q <= valid_d;
      gpio_q <= gpio_d;
    end
  // window close is applied last so a result latch beats a same-cycle read-clear
  always_comb begin
    cnt_d = cnt_q;
    hit_d = hit_q;
    ovf_d = ovf_q;
    res_d = res_q;
    valid_d = (rd && is_res) ? 1'b0 : valid_q;
    gpio_d = (wr && addr == ADDR_GPIO) ? wdata[GPIO_W-1:0] : gpio_q;
    if (inj_rise) begin
      cnt_d = '0;
      hit_d = '0;
      ovf_d = '0;
    end else if (inj_s) begin
      for (int i = 0; i < N_CH; i++)
        if (comp_s[i]) begin
          hit_d[i] = 1'b1;
`ifdef AFE_TOT_SATURATE_EN
          if (&cnt_q[i]) ovf_d[i] = 1'b1;
          else cnt_d[i] = cnt_q[i] + CNT_W'(1);
`else
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
`endif
        end
    end
    if (inj_fall) begin
      res_d = cnt_q;
      valid_d = 1'b1;
    end
  end
  always_comb begin
    status = '0;
    status[ST_VALID_BIT] = valid_q;
    for (int i = 0; i < N_CH; i++) begin
      status[ST_HIT_LSB + i] = hit_q[i];
      if (i < 7) status[ST_OVF_LSB + i] = ovf_q[i];
    end
  end
  always_comb begin
    rdata = addr == ADDR_GPIO ? 16'(gpio_q) : addr == ADDR_STATUS ? status : '0;
    for (int i = 0; i < N_CH; i++)
      if (is_res && ch == 7'(i)) rdata = 16'(res_q[i]);
  end
endmodule

// File: tb/tb_afe_tot_array.sv
// tb_afe_tot_array: scoreboard bench for afe_tot_array TOT counting, gating, overflow and SPI register access
module tb_afe_tot_array;
  localparam int HALF = 80;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic INJ_IN = 1'b0;
  logic CS_B = 1'b1;
  logic SCLK = 1'b0;
  logic MOSI = 1'b0;
  logic [3:0] COMP = '0;
  logic MISO, INJ_OUT;
  logic [3:0] HIT;
  logic [7:0] GPIO;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_val[$];
  logic [15:0] got_val[$];
  string exp_name[$];
`ifdef AFE_TOT_SATURATE_EN
  localparam logic [15:0] OVF_RES = 16'h00FF;
  localparam logic [15:0] OVF_ST = 16'h0100;
`else
  localparam logic [15:0] OVF_RES = 16'h002C;
  localparam logic [15:0] OVF_ST = 16'h0000;
`endif

  always #5 CLK = ~CLK;

  afe_tot_array dut (
    .CLK(CLK),
    .RST(RST),
    .INJ_IN(INJ_IN),
    .COMP(COMP),
    .CS_B(CS_B),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .MISO(MISO),
    .HIT(HIT),
    .INJ_OUT(INJ_OUT),
    .GPIO(GPIO)
  );

  task automatic cyc(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic expect_v(input string nm, input logic [15:0] v);
    exp_name.push_back(nm);
    exp_val.push_back(v);
  endtask

  task automatic pin(input string nm, input logic [15:0] act, input logic [15:0] e);
    expect_v(nm, e);
    got_val.push_back(act);
  endtask

  task automatic spi(input logic w, input logic [6:0] a, input logic [15:0] d, input int nb,
                     input bit cw, input int rst_at, output logic [15:0] r);
    logic [23:0] f;
    f = {w, a, d};
    r = '0;
    CS_B = 1'b0;
    #HALF;
    for (int i = 0; i < nb; i++) begin
      if (i == rst_at) begin
        RST = 1'b1;
        #HALF;
        RST = 1'b0;
      end
      MOSI = i < 24 ? f[23-i] : 1'b0;
      #HALF;
      SCLK = 1'b1;
      r = {r[14:0], MISO};
      #HALF;
      SCLK = 1'b0;
    end
    #HALF;
    CS_B = 1'b1;
    if (cw) INJ_IN = 1'b0;
    MOSI = 1'b0;
    cyc(10);
  endtask

  task automatic rd(input string nm, input logic [6:0] a, input logic [15:0] e, input bit cw = 1'b0);
    logic [15:0] r;
    expect_v(nm, e);
    spi(1'b0, a, 16'h0000, 24, cw, -1, r);
    got_val.push_back(r);
  endtask

  task automatic wr(input logic [6:0] a, input logic [15:0] d, input int nb = 24, input int rst_at = -1);
    logic [15:0] r;
    spi(1'b1, a, d, nb, 1'b0, rst_at, r);
  endtask

  task automatic window(input logic [3:0] c, input int n);
    INJ_IN = 1'b1;
    cyc(5);
    COMP = c;
    cyc(n);
    COMP = '0;
    cyc(5);
    INJ_IN = 1'b0;
    cyc(5);
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      while (got_val.size() > 0) begin
        logic [15:0] g;
        g = got_val.pop_front();
        compared++;
        if (exp_val.size() == 0) begin
          mismatched++;
          $display("FAIL orphan: observed %h, required an expectation", g);
        end else begin
          logic [15:0] e;
          string nm;
          e = exp_val.pop_front();
          nm = exp_name.pop_front();
          if (g !== e) begin
            mismatched++;
            $display("FAIL %s: got %h required %h", nm, g, e);
          end
        end
      end
    end
  end

  initial begin
    repeat (40000) @(posedge CLK);
    $display("FAIL timeout: simulation did not finish, compared %0d", compared);
    $fatal(1, "timeout");
  end

  initial begin
    @(negedge CLK);
    INJ_IN = 1'b1;
    cyc(4);
    pin("inj_out_in_reset", 16'(INJ_OUT), 16'h0001);
    pin("miso_in_reset", 16'(MISO), 16'h0000);
    pin("hit_in_reset", 16'(HIT), 16'h0000);
    pin("gpio_in_reset", 16'(GPIO), 16'h0000);
    INJ_IN = 1'b0;
    cyc(2);
    RST = 1'b0;
    cyc(5);
    pin("miso_after_reset", 16'(MISO), 16'h0000);
    pin("hit_after_reset", 16'(HIT), 16'h0000);
    pin("gpio_after_reset", 16'(GPIO), 16'h0000);
    rd("status_after_reset", 7'h01, 16'h0000);
    // gating: activity only outside the window
    window(4'b0000, 10);
    for (int i = 0; i < 10; i++) begin
      COMP[1] = ~COMP[1];
      cyc(2);
    end
    COMP = '0;
    cyc(5);
    pin("hit_gated", 16'(HIT), 16'h0000);
    rd("status_empty_window", 7'h01, 16'h8000);
    rd("res1_gated", 7'h11, 16'h0000);
    rd("status_cleared_gated", 7'h01, 16'h0000);
    // TOT of 37 cycles on channel 2
    window(4'b0100, 37);
    pin("hit_tot", 16'(HIT), 16'h0004);
    rd("status_tot", 7'h01, 16'h8004);
    rd("res2_tot", 7'h12, 16'h0025);
    rd("res0_tot", 7'h10, 16'h0000);
    rd("status_after_res_read", 7'h01, 16'h0004);
    // 300 cycles on an 8-bit counter
    window(4'b0001, 300);
    pin("hit_ovf", 16'(HIT), 16'h0001);
    rd("status_ovf", 7'h01, 16'h8001 | OVF_ST);
    rd("res0_ovf", 7'h10, OVF_RES);
    rd("res4_unmapped", 7'h14, 16'h0000);
    rd("status_valid_cleared", 7'h01, 16'h0001 | OVF_ST);
    // valid set by a close racing the read-clear
    window(4'b0000, 5);
    INJ_IN = 1'b1;
    cyc(10);
    COMP = 4'b1000;
    cyc(10);
    COMP = '0;
    cyc(5);
    rd("res0_race", 7'h10, 16'h0000, 1'b1);
    rd("status_race", 7'h01, 16'h8008);
    rd("res3_race", 7'h13, 16'h000A);
    rd("status_after_race", 7'h01, 16'h0008);
    // GPIO and write framing
    wr(7'h00, 16'h00A5);
    pin("gpio_write", 16'(GPIO), 16'h00A5);
    rd("gpio_read", 7'h00, 16'h00A5);
    wr(7'h00, 16'h005A, 23);
    pin("gpio_short_frame", 16'(GPIO), 16'h00A5);
    wr(7'h00, 16'h005A, 25);
    pin("gpio_long_frame", 16'(GPIO), 16'h00A5);
    wr(7'h01, 16'hFFFF);
    rd("status_ro", 7'h01, 16'h0008);
    wr(7'h13, 16'hFFFF);
    rd("res3_ro", 7'h13, 16'h000A);
    wr(7'h00, 16'h1234);
    pin("gpio_trunc", 16'(GPIO), 16'h0034);
    rd("gpio_read_trunc", 7'h00, 16'h0034);
    pin("miso_idle", 16'(MISO), 16'h0000);
    // reset in mid-frame aborts the write
    wr(7'h00, 16'h00FF, 24, 12);
    pin("gpio_reset_midframe", 16'(GPIO), 16'h0000);
    pin("hit_reset_midframe", 16'(HIT), 16'h0000);
    rd("status_reset_midframe", 7'h01, 16'h0000);
    rd("res3_reset_midframe", 7'h13, 16'h0000);
    for (int i = 0; i < 200 && got_val.size() > 0; i++) cyc(1);
    if (got_val.size() != 0 || exp_val.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: %0d observations and %0d expectations left, required 0",
               got_val.size(), exp_val.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
